// File: rtl/bp_pkg.sv
// ============================================================================
// Module  : bp_pkg
// Shared types and helpers for the gshare/BTB branch predictor.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int CTR_MAX_W = 8;
    localparam int TAG_MAX_W = 30;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    // Tag is held zero-extended to the widest possible tag; the BTB keeps only
    // the bits its index width leaves meaningful.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    function automatic ctr_t sat_inc(input ctr_t v, input int w);
        ctr_t max_v;
        max_v = ctr_t'((1 << w) - 1);
        return (v >= max_v) ? max_v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? '0 : v - ctr_t'(1);
    endfunction

    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_btb.sv
// ============================================================================
// Module  : bp_btb
// Direct-mapped tagged BTB: combinational lookup, one write port, async valid clear.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bp_btb
    import bp_pkg::*;
#(
    parameter int BTB_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BTB_BITS-1:0]  rd_idx_i,
    input  logic [TAG_MAX_W-1:0] rd_tag_i,
    output logic                 rd_hit_o,
    output logic [31:0]          rd_target_o,
    input  logic                 wr_en_i,
    input  logic [BTB_BITS-1:0]  wr_idx_i,
    input  btb_entry_t           wr_entry_i
);

    localparam int ENTRIES = 1 << BTB_BITS;
    localparam int TAG_W   = TAG_MAX_W - BTB_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic               unused_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
        end
    end

    // Payload needs no reset: it is never observed while its valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_entry_i.tag[TAG_W-1:0];
            tgt_q[wr_idx_i] <= wr_entry_i.target;
        end
    end

    assign rd_hit_o    = valid_q[rd_idx_i] && (rd_tag_i == TAG_MAX_W'(tag_q[rd_idx_i]));
    assign rd_target_o = tgt_q[rd_idx_i];

    assign unused_tag  = ^wr_entry_i.tag[TAG_MAX_W-1:TAG_W];

endmodule

`default_nettype wire

// File: rtl/gshare_btb_predictor.sv
// ============================================================================
// Module  : gshare_btb_predictor
// IF-stage gshare + BTB predictor; optional return stack via GSHARE_BTB_RAS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter int PHT_BITS  = 6,
    parameter int HIST_BITS = 6,
    parameter int CTR_BITS  = 2,
    parameter int BTB_BITS  = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        ready_in,
    input  logic [31:0] PC_IF,
    input  logic [31:0] IM_IF,
    input  logic        jump_ena_IF,
    input  logic        jump_alw_IF,
    input  logic        jump_ind_IF,
    output logic        jump_pred_IF,
    output logic [31:0] jump_addr_IF,
    input  logic [31:0] PC_EX,
    input  logic        jump_ena_EX,
    input  logic        jump_alw_EX,
    input  logic        jump_ind_EX,
    input  logic        jump_taken_EX,
    input  logic [31:0] jump_target_EX,
    input  logic        is_call_IF,
    input  logic        is_ret_IF
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;

    logic [CTR_BITS-1:0]  pht_q [PHT_ENTRIES];
    logic [CTR_BITS-1:0]  pht_upd;
    logic [HIST_BITS-1:0] gbh_q, gbh_d, gbh_shift;
    logic [PHT_BITS-1:0]  r_idx, w_idx;
    logic                 train_cond, train_ind;
    logic [31:0]          fall_addr;
    logic                 btb_hit;
    logic [31:0]          btb_target;
    btb_entry_t           btb_wr;
    logic                 unused_pc_ex;

    assign r_idx      = PC_IF[PHT_BITS+1:2] ^ PHT_BITS'(gbh_q);
    assign w_idx      = PC_EX[PHT_BITS+1:2] ^ PHT_BITS'(gbh_q);
    assign fall_addr  = PC_IF + IM_IF;

    assign train_cond = ready_in && jump_ena_EX && !jump_alw_EX && !jump_ind_EX;
    assign train_ind  = ready_in && jump_ena_EX && jump_ind_EX && jump_taken_EX;

    assign pht_upd = jump_taken_EX ? CTR_BITS'(sat_inc(ctr_t'(pht_q[w_idx]), CTR_BITS))
                                   : CTR_BITS'(sat_dec(ctr_t'(pht_q[w_idx])));

    // ------------------------------------------------------------------
    // Pattern history table and global history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= '1;
            end
        end else if (train_cond) begin
            pht_q[w_idx] <= pht_upd;
        end
    end

    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign gbh_shift = jump_taken_EX;
        end else begin : g_hist_shift
            assign gbh_shift = {gbh_q[HIST_BITS-2:0], jump_taken_EX};
        end
    endgenerate

    assign gbh_d = train_cond ? gbh_shift : gbh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gbh_q <= '0;
        end else begin
            gbh_q <= gbh_d;
        end
    end

    // ------------------------------------------------------------------
    // Branch target buffer for indirect jumps
    // ------------------------------------------------------------------
    assign btb_wr.valid  = 1'b1;
    assign btb_wr.tag    = TAG_MAX_W'(PC_EX[31:BTB_BITS+2]);
    assign btb_wr.target = jump_target_EX;

    bp_btb #(
        .BTB_BITS (BTB_BITS)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (PC_IF[BTB_BITS+1:2]),
        .rd_tag_i    (TAG_MAX_W'(PC_IF[31:BTB_BITS+2])),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .wr_en_i     (train_ind),
        .wr_idx_i    (PC_EX[BTB_BITS+1:2]),
        .wr_entry_i  (btb_wr)
    );

    assign unused_pc_ex = ^PC_EX[1:0];

`ifdef GSHARE_BTB_RAS_EN
    // ------------------------------------------------------------------
    // Circular return address stack; ptr addresses the next free slot
    // ------------------------------------------------------------------
    localparam int RAS_PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    logic [29:0]          ras_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d, ras_top_idx, ras_wr_idx;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic                 ras_adv, ras_avail, ras_pop, ras_push;
    logic [29:0]          ras_top;

    assign ras_adv     = valid_in && ready_in && jump_ena_IF;
    assign ras_avail   = (ras_cnt_q != '0);
    assign ras_top_idx = ras_ptr_q - RAS_PTR_W'(1);
    assign ras_top     = ras_q[ras_top_idx];
    assign ras_pop     = ras_adv && is_ret_IF && ras_avail;
    assign ras_push    = ras_adv && is_call_IF;

    // A coroutine pops first, so its push reuses the slot just freed.
    always_comb begin
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr_idx = ras_ptr_q;
        if (ras_pop) begin
            ras_ptr_d  = ras_top_idx;
            ras_cnt_d  = ras_cnt_q - RAS_CNT_W'(1);
            ras_wr_idx = ras_top_idx;
        end
        if (ras_push) begin
            ras_ptr_d = ras_wr_idx + RAS_PTR_W'(1);
            if (ras_cnt_d != RAS_CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_d + RAS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_q[ras_wr_idx] <= PC_IF[31:2] + 30'd1;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{valid_in, is_call_IF, is_ret_IF} ^ (RAS_DEPTH == 0);
`endif

    // ------------------------------------------------------------------
    // Combinational prediction
    // ------------------------------------------------------------------
    always_comb begin
        jump_pred_IF = 1'b0;
        jump_addr_IF = fall_addr;
        if (jump_ena_IF) begin
            if (jump_ind_IF) begin
                jump_pred_IF = btb_hit;
                if (btb_hit) begin
                    jump_addr_IF = btb_target;
                end
            end else if (jump_alw_IF) begin
                jump_pred_IF = 1'b1;
            end else begin
                jump_pred_IF = pht_q[r_idx][CTR_BITS-1];
            end
`ifdef GSHARE_BTB_RAS_EN
            if (is_ret_IF && ras_avail) begin
                jump_pred_IF = 1'b1;
                jump_addr_IF = {ras_top, 2'b00};
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: doc/gshare_btb_predictor.md
Name: gshare_btb_predictor

Overview:
Next-generation IF-stage branch predictor. A parametrised gshare PHT (configurable index, history and counter widths) predicts conditional branches. A direct-mapped tagged BTB predicts indirect-jump (JALR) targets, which the previous predictor always predicted not taken. Prediction is combinational in IF; training happens from EX on pipeline advance.

Parameters:
PHT_BITS, 6, PHT index width; PHT has 2**PHT_BITS entries
HIST_BITS, 6, global history length; legal range 1..PHT_BITS
CTR_BITS, 2, saturating counter width per PHT entry; must be >= 1
BTB_BITS, 4, BTB index width; BTB has 2**BTB_BITS entries
RAS_DEPTH, 4, return address stack depth; power of 2, used only with RAS_EN

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
valid_in  in  1  IF instruction valid
ready_in  in  1  pipeline advance; all state updates are gated by it
PC_IF  in  32  PC of instruction in IF
IM_IF  in  32  immediate of instruction in IF
jump_ena_IF  in  1  IF instruction is a branch/jump
jump_alw_IF  in  1  unconditional (JAL/JALR)
jump_ind_IF  in  1  indirect (JALR)
jump_pred_IF  out  1  predicted taken
jump_addr_IF  out  32  predicted target
PC_EX  in  32  PC of resolving instruction
jump_ena_EX  in  1  EX instruction is a branch/jump
jump_alw_EX  in  1  unconditional
jump_ind_EX  in  1  indirect
jump_taken_EX  in  1  resolved taken
jump_target_EX  in  32  resolved target address
is_call_IF  in  1  (RAS_EN only) JAL/JALR with rd in {x1,x5}
is_ret_IF  in  1  (RAS_EN only) JALR with rs1 in {x1,x5}, rd=x0

Behaviour:
- Reset (async): all PHT counters = all ones (strongly taken); GBH = 0; all BTB valid bits = 0; RAS pointer/count = 0. Outputs are combinational; after reset, jump_pred_IF = 1 only for conditional branches and JAL.
- Indexing: rIdx = PC_IF[PHT_BITS+1:2] ^ zero-extended GBH; wIdx is the same with PC_EX. BTB index = PC[BTB_BITS+1:2]; BTB tag = PC[31:BTB_BITS+2].
- Prediction is combinational with 0-cycle latency and is qualified only by jump_ena_IF:
  - conditional (!alw): pred = PHT[rIdx] MSB; addr = PC_IF + IM_IF (32-bit wrap).
  - JAL (alw && !ind): pred = 1; addr = PC_IF + IM_IF.
  - JALR (ind): pred = BTB hit (valid && tag match); addr = BTB target. On miss, pred = 0 and addr = PC_IF + IM_IF (don't care).
- Training occurs on the clk edge when ready_in && jump_ena_EX.
  - Conditional: PHT[wIdx] saturating +1 if taken, saturating -1 if not. Never wraps; CTR_BITS=1 degenerates to last-outcome. GBH <= {GBH[HIST_BITS-2:0], taken}.
  - Indirect and taken: BTB[idx] <= {valid=1, tag, jump_target_EX}, overwriting any conflicting entry. Not-taken indirect leaves the BTB unchanged.
  - JAL: no state change.
- Read/write to the same entry in one cycle: IF sees the old value; the update is visible next cycle.
- When ready_in = 0, no state changes; outputs still track the IF inputs.
- Reset asserted mid-operation clears state immediately, regardless of clk or ready_in.

Optional Feature:
GSHARE_BTB_RAS_EN:
- Defined: circular RAS of RAS_DEPTH x 30-bit entries (PC[31:2]), updated on valid_in && ready_in && jump_ena_IF.
  - Call pushes PC_IF+4.
  - Return pops and overrides the prediction: pred = 1, addr = {top,2'b00}, if count > 0. With count = 0, fall back to the BTB.
  - Call and return together (coroutine): pop then push; the predicted address is the popped value.
  - Overflow overwrites the oldest entry; count saturates at RAS_DEPTH.
  - No repair on flush.
- Undefined: is_call_IF and is_ret_IF are ignored (ports are still present), no RAS storage exists, and JALR uses the BTB only.

Decomposition:
- Package bp_pkg: btb_entry_t struct {valid, tag, target}; sat_inc/sat_dec functions parametrised via width-generic casting; ras_ptr width localparam.
- One sub-module, bp_btb: tagged direct-mapped storage with combinational lookup port, write port, and async valid clear.
- PHT, GBH and RAS stay in the top level.

Test Plan:
- Reset, then IF cond PC=0x100 IM=0x20 -> pred=1, addr=0x120. Two not-taken EX updates at PC_EX=0x100 (GBH stays 0, PHT[0] 3->2->1) -> IF PC=0x100 pred=0.
- Reset, then taken EX update at PC_EX=0x100 -> PHT[0] stays 3 (no wrap) and GBH=1. IF PC=0x104 maps to index 1^1=0 -> pred=1.
- JAL PC=0x40 IM=0xFFFFFFF0 -> pred=1, addr=0x30. After any EX JAL update, GBH/PHT unchanged.
- Indirect EX PC=0x200 taken to 0x3000, then next cycle IF ind PC=0x200 -> pred=1, addr=0x3000. IF ind PC=0x1200 (same index, different tag) -> pred=0. Same-cycle IF read during the write -> pred=0.
- BTB entry loaded, then reset pulsed asynchronously between edges -> IF ind PC=0x200 pred=0 immediately. With ready_in=0, EX updates are ignored.
- (GSHARE_BTB_RAS_EN) call at 0x80, then return -> pred=1, addr=0x84. Five calls at 0x10,0x20,0x30,0x40,0x50, then five returns -> 0x54,0x44,0x34,0x24, then the fifth falls back to the BTB (pred=0 on miss).
